// File: rtl/stream_loader_pkg.sv
// Shared definitions for the stream loader.
// State encoding for the load FSM.
package stream_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_LOAD  = 2'd1;
  localparam state_t S_FLUSH = 2'd2;
  localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/sum_acc.sv
// Modular accumulator for the running load checksum.
// Ports: clk, reset (async low), clr, en, din -> sum.
module sum_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/stream_loader.sv
// Streams framed words into consecutive RAM addresses from a base.
// Ports: load ctrl in, valid/ready stream in, RAM write strobe out, status.
module stream_loader
  import stream_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int WRAP   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              write_rq,
  output logic [ADDR_W-1:0] addrOut,
  output logic [DATA_W-1:0] dataOut,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [DATA_W-1:0] checksum
);

  localparam logic WRAP_EN = (WRAP != 0);

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   count_inc;
  logic              accept;
  logic              start_ok;
  logic              last;
  logic              at_top;
  logic              ovf_hit;

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign accept    = in_valid & in_ready;
  assign start_ok  = load_start & (state == S_IDLE);
  assign count_inc = count + 1'b1;
  assign last      = (count_inc == len_q);
  assign at_top    = &cur_addr;
  // Stepping past the top without wrap ends the load after this word.
  assign ovf_hit   = at_top & ~WRAP_EN;

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == S_IDLE: begin
        if (load_start) begin
          state_nx = (load_len == '0) ? S_DONE : S_LOAD;
        end
      end
      state == S_LOAD: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (accept && (ovf_hit || last)) begin
          state_nx = S_FLUSH;
        end
      end
      state == S_FLUSH: begin
        state_nx = abort ? S_IDLE : S_DONE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cur_addr <= '0;
      count    <= '0;
      len_q    <= '0;
      overflow <= 1'b0;
      write_rq <= 1'b0;
      addrOut  <= '0;
      dataOut  <= '0;
    end else begin
      state    <= state_nx;
      write_rq <= accept;
      if (start_ok) begin
        cur_addr <= load_base;
        len_q    <= load_len;
        count    <= '0;
        overflow <= 1'b0;
      end else if (accept) begin
        addrOut  <= cur_addr;
        dataOut  <= in_data;
        cur_addr <= cur_addr + 1'b1;
        count    <= count_inc;
        if (ovf_hit) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  sum_acc #(
    .DATA_W (DATA_W)
  ) u_sum (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (accept),
    .din   (in_data),
    .sum   (checksum)
  );

endmodule

// File: doc/stream_loader.md
# stream_loader

Parametrised successor to the byte loader. It accepts a framed stream of words over a valid/ready handshake and writes them to consecutive RAM addresses starting at a programmable base, emitting one single-cycle write strobe per word. It adds length-bounded loads, overflow/wrap handling, abort, a done pulse and a running checksum. It sits between the host link deserialiser and the program/data RAM write port.

## Interface
- DATA_W, 8, word width of stream and RAM
- ADDR_W, 9, RAM address width
- WRAP, 0, 1 = address wraps to 0 past 2^ADDR_W-1; 0 = overflow terminates the load
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- load_start  in  1  one-cycle request to begin a load; honoured only in IDLE
- load_base  in  ADDR_W  first write address, sampled with load_start
- load_len  in  ADDR_W+1  word count, sampled with load_start (0 legal)
- abort  in  1  terminate current load, return to IDLE without done
- in_valid  in  1  in_data valid
- in_data  in  DATA_W  stream word
- in_ready  out  1  loader can accept a word this cycle
- write_rq  out  1  one-cycle RAM write strobe
- addrOut  out  ADDR_W  write address, valid when write_rq=1
- dataOut  out  DATA_W  write data, valid when write_rq=1
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse, load finished (normally or by overflow)
- overflow  out  1  sticky; set when WRAP=0 and address space exhausted; cleared by next load_start
- checksum  out  DATA_W  sum mod 2^DATA_W of words accepted in current/last load

## Operation
- All outputs reset to 0; state IDLE.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE: load_start=1 -> capture base/len, clear count, checksum, overflow; go LOAD (len=0 -> DONE directly).
- LOAD: in_ready=1. Accept on in_valid&in_ready: register dataOut=in_data, addrOut=cur_addr, write_rq=1 next cycle; cur_addr+=1, count+=1, checksum+=in_data. Accepting the word that makes count==len -> FLUSH.
- Address step with cur_addr==2^ADDR_W-1: WRAP=1 -> cur_addr=0; WRAP=0 -> that word is still written, overflow=1, go FLUSH (remaining words not accepted).
- FLUSH: in_ready=0; the registered final write_rq appears; next -> DONE.
- DONE: done=1 for one cycle, -> IDLE. checksum holds until next load_start.
- abort in LOAD/FLUSH: next state IDLE, in_ready=0 next cycle, no done; a write already registered still issues its write_rq. abort in IDLE/DONE ignored.
- load_start outside IDLE ignored. abort and load_start together in IDLE: load_start wins.
- Count and length compare at ADDR_W+1 bits; len up to 2^ADDR_W legal.

## Timing
- load_start sampled at edge 0 -> busy=1, in_ready=1 from cycle 1.
- Word accepted at edge k -> write_rq=1 in cycle k+1 (latency 1); back-to-back acceptance gives back-to-back strobes, throughput 1 word/cycle.
- Last word accepted at edge k -> in_ready=0 from k+1, write_rq in k+1, done in k+2, busy=0 from k+3.
- len=0: done in cycle 1, no write_rq.
- Async reset mid-load: all outputs 0 immediately, no further write_rq.

## Structure
- Shared package: state encoding typedef (IDLE/LOAD/FLUSH/DONE); no other constants.
- Single module; checksum accumulator may be a sub-module `sum_acc` (parametrised DATA_W, clear/enable).

## Test plan
- base=0x010, len=4, words 0x11,0x22,0x33,0x44 back-to-back -> write_rq four consecutive cycles at 0x010..0x013, done 1 cycle after last write, checksum=0xAA.
- Same load with in_valid toggling every other cycle -> identical writes/addresses, in_ready never drops until last word.
- WRAP=0, base=0x1FE, len=5 -> writes at 0x1FE,0x1FF only, overflow=1, done pulse, in_ready=0 after second word.
- WRAP=1, base=0x1FF, len=3 -> writes at 0x1FF,0x000,0x001, overflow=0.
- len=3, abort after second word accepted -> two write_rq, no done, busy=0 two cycles later; new load_start then works with overflow/checksum cleared.
- Reset asserted mid-load (after 1 of 4 words) -> all outputs 0 asynchronously; load_start with len=0 after release -> done in cycle 1, no write_rq.
